// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, addresses the asynchronous instruction
// memory and buffers one fetched word toward decode, with stall, redirect and flush.
module fetch_stage #(
    parameter int          ADDR_WIDTH = 8,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_data,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic [31:0]           pc_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    input  logic                  redirect,
    input  logic [31:0]           redirect_target,
    output logic                  misalign_err,
    output logic [31:0]           fetch_count
);

    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    logic [31:0] pc;
    logic        transfer;
    logic        buf_free;

    // Handshake: a word moves to decode on any rising edge where valid_out && ready_in
    // and no redirect is present; once valid_out is high, instr_out/pc_out are frozen
    // until that happens or a redirect discards them.
    assign transfer = valid_out && ready_in && !redirect;
    assign buf_free = !valid_out || (ready_in && !redirect);

    // Upper PC bits are ignored so fetches wrap silently around the memory depth.
    assign imem_addr = pc[ADDR_WIDTH+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            valid_out    <= 1'b0;
            instr_out    <= NOP;
            pc_out       <= 32'h0000_0000;
            misalign_err <= 1'b0;
            fetch_count  <= 32'h0000_0000;
        end else begin
            if (transfer) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (redirect) begin
                pc        <= {redirect_target[31:2], 2'b00};
                valid_out <= 1'b0;
                if (redirect_target[1:0] != 2'b00) begin
                    misalign_err <= 1'b1;
                end
            end else if (buf_free) begin
                instr_out <= imem_data;
                pc_out    <= pc;
                valid_out <= 1'b1;
                pc        <= pc + 32'd4;
            end
        end
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end sitting directly upstream of the asynchronous instruction memory.
- Owns the program counter and drives the memory's word address.
- Captures the combinational instruction word returned in the same cycle into an output buffer.
- Presents the buffered instruction and its PC to decode through a valid/ready handshake; supports stall, redirect (branch/jump) and flush.

Parameters:
ADDR_WIDTH, 8, instruction-memory word-address width (memory depth 2**ADDR_WIDTH words)
DATA_WIDTH, 32, instruction width
RESET_PC, 32'h0000_0000, byte address of the first fetch after reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
imem_addr  output  ADDR_WIDTH  word address to instruction memory = pc[ADDR_WIDTH+1:2]
imem_data  input  DATA_WIDTH  instruction returned combinationally for imem_addr
instr_out  output  DATA_WIDTH  buffered instruction to decode
pc_out  output  32  byte PC of instr_out
valid_out  output  1  instr_out/pc_out hold a valid instruction
ready_in  input  1  decode accepts this cycle
redirect  input  1  branch/jump taken; discard buffered instruction, refetch at target
redirect_target  input  32  byte address of the new fetch
misalign_err  output  1  sticky: a redirect_target with bits [1:0] != 0 was received
fetch_count  output  32  number of completed handshakes since reset

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-to-clk release): pc=RESET_PC, valid_out=0, instr_out=32'h0000_0013 (NOP), pc_out=0, misalign_err=0, fetch_count=0.
- imem_addr is combinational from the pc register only; it never depends on imem_data or ready_in.
- Transfer occurs in a cycle when valid_out && ready_in && !redirect. On a transfer, fetch_count increments, wrapping at 2**32.
- Buffer free this cycle = !valid_out || (ready_in && !redirect).
- Priority per rising edge:
  1. Redirect (redirect high):
     - pc <= {redirect_target[31:2],2'b00}
     - valid_out <= 0; buffered instruction is discarded, no transfer counted
     - instr_out/pc_out hold their old values
     - if redirect_target[1:0] != 0, misalign_err <= 1; it stays set until reset.
  2. Advance (buffer free):
     - instr_out <= imem_data; pc_out <= pc; valid_out <= 1; pc <= pc+4.
  3. Stall (valid_out && !ready_in):
     - pc, instr_out, pc_out and valid_out all hold.
     - instr_out must not change while valid_out is high and not accepted.
- Latency:
  - First valid_out rises one cycle after reset release, with pc_out=RESET_PC.
  - After a redirect in cycle N, valid_out is 0 in cycle N+1. The target instruction appears with valid_out=1 in cycle N+2.
- Throughput: one instruction per cycle when ready_in is held high.
- Wrap-around:
  - pc+4 is modulo 2**32.
  - imem_addr wraps modulo 2**ADDR_WIDTH (upper pc bits ignored), with no error flagged.
- Redirect while stalled: the stalled instruction is dropped and the target is fetched.
- Redirect every cycle: valid_out stays 0 and pc tracks each target.
- Reset mid-stall or mid-redirect: everything returns to reset values immediately; pending redirect is lost.

Test Plan:
- Reset then ready_in=1 for 4 cycles, program 0x11,0x22,0x33,0x44 → outputs (pc_out,instr_out) = (0,0x11),(4,0x22),(8,0x33),(C,0x44) on consecutive cycles; fetch_count=4.
- Stall: ready_in=0 for 3 cycles while valid_out=1 with pc_out=8 → imem_addr stays 3; instr_out and pc_out stable; on release, next outputs are pc_out=8 then pc_out=C; count increments by 1 per accept.
- Redirect to 0x40 at pc_out=8 with ready_in=1 → no transfer counted that cycle; next cycle valid_out=0; following cycle pc_out=0x40, instr_out=mem[16].
- Misaligned redirect to 0x46 → fetch resumes at 0x44, misalign_err=1; it stays 1 across later redirects until rst_n pulses low.
- Wrap: redirect to 0x3FC with ADDR_WIDTH=8 → fetches word 255, then pc=0x400 with imem_addr=0.
- Assert rst_n low mid-stall with no clock edge → valid_out=0, pc=RESET_PC and fetch_count=0 immediately.
